// File: rtl/fir_ctrl.sv
// fir_ctrl: coefficient-bank and stream controller for an L-tap FIR datapath.
// Define FIR_CTRL_FLUSH_EN to push L-1 tagged zeros through the filter at end of stream.
module fir_ctrl #(
  parameter int W_IN  = 11,
  parameter int W_O   = 13,
  parameter int L     = 4,
  parameter int MPIPE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [$clog2(L)-1:0]   cfg_addr,
  input  logic [W_IN-1:0]        cfg_data,
  input  logic                   cfg_commit,
  input  logic                   s_valid,
  input  logic [W_IN-1:0]        s_data,
  output logic                   s_ready,
  input  logic                   flush_req,
  output logic                   busy,
  output logic                   underrun,
  output logic                   dp_load_val,
  output logic [W_IN-1:0]        dp_val_in,
  output logic [L*W_IN-1:0]      dp_coeff,
  input  logic [W_O-1:0]         dp_fir_out,
  output logic                   m_valid,
  output logic [W_O-1:0]         m_data
);

  localparam int LAT = MPIPE + 2;

`ifdef FIR_CTRL_FLUSH_EN
  localparam int FW = $clog2(L) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, RUN, FLUSH} state_t;
  logic [FW-1:0] r_fl_cnt;
`else
  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, RUN} state_t;
`endif

  state_t                 r_state;
  logic [L-1:0][W_IN-1:0] r_shadow;
  logic [L*W_IN-1:0]      r_dp_coeff;
  logic [W_IN-1:0]        r_dp_val_in;
  logic [LAT-1:0]         r_tag;
  logic                   r_s_ready;
  logic                   r_underrun;
  logic                   r_dp_load_val;
  logic                   w_tag_in;

  // A tag marks a slot that carries a real sample (or a flush tail zero).
  always_comb begin
    w_tag_in = (r_state == RUN) && s_valid;
`ifdef FIR_CTRL_FLUSH_EN
    if (r_state == FLUSH) w_tag_in = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_shadow      <= '0;
      r_dp_coeff    <= '0;
      r_dp_val_in   <= '0;
      r_tag         <= '0;
      r_s_ready     <= 1'b0;
      r_underrun    <= 1'b0;
      r_dp_load_val <= 1'b1;
`ifdef FIR_CTRL_FLUSH_EN
      r_fl_cnt      <= '0;
`endif
    end else begin
      r_tag         <= {r_tag[LAT-2:0], w_tag_in};
      r_dp_val_in   <= '0;
      r_underrun    <= 1'b0;
      r_s_ready     <= 1'b0;
      r_dp_load_val <= 1'b1;
      case (r_state)
        IDLE: begin
          if (cfg_we) begin
            r_shadow[cfg_addr] <= cfg_data;
            r_state            <= LOAD;
          end else if (s_valid) begin
            r_state   <= RUN;
            r_s_ready <= 1'b1;
          end
        end
        LOAD: begin
          // Commit takes priority; a write in the same cycle is dropped.
          if (cfg_commit) begin
            r_state       <= COMMIT;
            r_dp_coeff    <= r_shadow;
            r_dp_load_val <= 1'b0;
          end else if (cfg_we) begin
            r_shadow[cfg_addr] <= cfg_data;
          end
        end
        COMMIT: r_state <= IDLE;
        RUN: begin
          r_dp_val_in <= s_valid ? s_data : '0;
          r_underrun  <= ~s_valid;
          if (flush_req) begin
`ifdef FIR_CTRL_FLUSH_EN
            if (L > 1) begin
              r_state  <= FLUSH;
              r_fl_cnt <= FW'(L - 1);
            end else begin
              r_state  <= IDLE;
            end
`else
            r_state <= IDLE;
`endif
          end else begin
            r_s_ready <= 1'b1;
          end
        end
`ifdef FIR_CTRL_FLUSH_EN
        FLUSH: begin
          r_fl_cnt <= r_fl_cnt - FW'(1);
          if (r_fl_cnt == FW'(1)) r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready     = r_s_ready;
  assign underrun    = r_underrun;
  assign dp_load_val = r_dp_load_val;
  assign dp_val_in   = r_dp_val_in;
  assign dp_coeff    = r_dp_coeff;
  assign busy        = (r_state != IDLE) || (|r_tag);
  assign m_valid     = r_tag[LAT-1];
  assign m_data      = m_valid ? dp_fir_out : '0;

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed stimulus with a queue scoreboard against a behavioural FIR datapath stub.
module tb_fir_ctrl;
  localparam int W_IN = 11, W_O = 13, L = 4, MPIPE = 3;
  localparam int LAT = MPIPE + 2;
  localparam int AW = $clog2(L);
  localparam int SW = 2*W_IN + 2;
  localparam int SH = SW - W_O;
`ifdef FIR_CTRL_FLUSH_EN
  localparam int TAILN = L - 1;
`else
  localparam int TAILN = 0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we, cfg_commit, s_valid, s_ready, flush_req, busy, underrun;
  logic dp_load_val, m_valid;
  logic [AW-1:0]       cfg_addr;
  logic [W_IN-1:0]     cfg_data, s_data, dp_val_in;
  logic [L*W_IN-1:0]   dp_coeff;
  logic [W_O-1:0]      dp_fir_out, m_data;

  fir_ctrl #(.W_IN(W_IN), .W_O(W_O), .L(L), .MPIPE(MPIPE)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush_req(flush_req), .busy(busy), .underrun(underrun), .dp_load_val(dp_load_val),
    .dp_val_in(dp_val_in), .dp_coeff(dp_coeff), .dp_fir_out(dp_fir_out),
    .m_valid(m_valid), .m_data(m_data)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stub: one delay-line register plus MPIPE result stages gives LAT from acceptance.
  logic signed [W_IN-1:0] xd [L] = '{default: '0};
  logic signed [SW-1:0]   pp [MPIPE] = '{default: '0};
  logic signed [SW-1:0]   w_sum;
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < L; i++)
      w_sum = w_sum + SW'($signed(dp_coeff[i*W_IN +: W_IN])) * SW'(xd[i]);
  end
  always @(posedge clk) begin
    xd[0] <= dp_val_in;
    for (int i = 1; i < L; i++) xd[i] <= xd[i-1];
    pp[0] <= w_sum;
    for (int i = 1; i < MPIPE; i++) pp[i] <= pp[i-1];
  end
  assign dp_fir_out = pp[MPIPE-1][SW-1 -: W_O];

  typedef struct { logic [W_O-1:0] d; int c; } exp_t;
  exp_t sbq[$];
  int vecs = 0, errs = 0, mv_cnt = 0, und_cnt = 0;
  logic mon_en = 1'b0;
  int coef[L] = '{124, 214, 57, 33};
  int hist[L];
  logic [L*W_IN-1:0] exp_coeff;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (underrun === 1'b1) und_cnt++;
      if (m_valid === 1'b1) begin
        mv_cnt++;
        if (sbq.size() == 0) chk("unexpected_m_valid", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("m_valid_cycle", cyc, e.c);
          chk("m_data", m_data, e.d);
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic hist_clr(); for (int i = 0; i < L; i++) hist[i] = 0; endtask
  task automatic hist_push(input int d);
    for (int i = L-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
  endtask
  function automatic logic [W_O-1:0] ref_y();
    int s = 0;
    for (int i = 0; i < L; i++) s += coef[i] * hist[i];
    return W_O'(s >>> SH);
  endfunction
  task automatic push(input logic [W_O-1:0] d, input int c); sbq.push_back('{d, c}); endtask

  // Holds the sample until the handshake completes; returns the acceptance cycle.
  task automatic send(input int d, input logic fl, output int t);
    s_valid = 1'b1; s_data = W_IN'(d); flush_req = fl; t = -1;
    for (int k = 0; k < 20 && t < 0; k++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin t = cyc; hist_push(d); end
      tick();
    end
    s_valid = 1'b0; s_data = '0; flush_req = 1'b0;
    if (t < 0) chk("send_timeout", 0, 1);
  endtask
  task automatic send_m(input int d, input logic fl);
    int t;
    send(d, fl, t);
    push(ref_y(), t + LAT);
`ifdef FIR_CTRL_FLUSH_EN
    if (fl) for (int k = 1; k < L; k++) begin hist_push(0); push(ref_y(), t + k + LAT); end
`endif
  endtask
  task automatic drain(input string nm);
    repeat (LAT + L + 4) tick();
    chk({nm, "_sb_empty"}, sbq.size(), 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic load_coeffs(input logic checks);
    for (int i = 0; i < L; i++) begin
      cfg_we = 1'b1; cfg_addr = AW'(i); cfg_data = W_IN'(coef[i]); tick();
    end
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = W_IN'(7); cfg_commit = 1'b1;
    @(negedge clk);
    if (checks) chk("load_val_before_commit", dp_load_val, 1);
    tick(); cfg_we = 1'b0; cfg_commit = 1'b0;
    @(negedge clk);
    chk("commit_load_val_low", dp_load_val, 0);
    chk("commit_coeff", dp_coeff, exp_coeff);
    tick();
    @(negedge clk);
    if (checks) begin
      chk("load_val_high_after", dp_load_val, 1);
      chk("coeff_held", dp_coeff, exp_coeff);
    end
  endtask

  initial begin
    int t, u0, m0;
    int smp[8] = '{300, -250, 1000, -1024, 512, 77, -600, 900};
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, u0, m0;
    int smp[8] = '{300, -250, 1000, -1024, 512, 77, -600, 900};
    for (int i = 0; i < L; i++) exp_coeff[i*W_IN +: W_IN] = W_IN'(coef[i]);
    cfg_we = 0; cfg_commit = 0; cfg_addr = '0; cfg_data = '0;
    s_valid = 0; s_data = '0; flush_req = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_val", dp_load_val, 1);
    chk("rst_coeff", dp_coeff, 0);
    chk("rst_val_in", dp_val_in, 0);
    tick(); rst = 1'b0; mon_en = 1'b1;

    load_coeffs(1'b1);

    // Impulse: hand-computed (c*1023)>>>11 tail.
    hist_clr();
    send(1023, 0, t); push(13'd61, t + LAT);
    send(0, 0, t);    push(13'd106, t + LAT);
    send(0, 0, t);    push(13'd28, t + LAT);
    send(0, 1, t);    push(13'd16, t + LAT);
`ifdef FIR_CTRL_FLUSH_EN
    for (int k = 1; k < L; k++) push(13'd0, t + k + LAT);
`endif
    drain("impulse");

    // One-cycle gap mid-stream.
    hist_clr(); u0 = und_cnt;
    send_m(100, 0); send_m(-200, 0); send_m(300, 0);
    @(negedge clk);
    chk("gap_in_run", s_ready, 1);
    hist_push(0);
    tick();
    send_m(400, 0); send_m(-500, 1);
    drain("underrun");
    chk("underrun_pulses", und_cnt - u0, 1);

    // cfg_we beats s_valid in IDLE.
    cfg_we = 1'b1; cfg_addr = AW'(1); cfg_data = W_IN'(coef[1]); s_valid = 1'b1; s_data = W_IN'(55);
    tick();
    cfg_we = 1'b0; s_valid = 1'b0; cfg_commit = 1'b1;
    @(negedge clk);
    chk("idle_cfg_wins_ready", s_ready, 0);
    chk("idle_cfg_wins_busy", busy, 1);
    tick(); cfg_commit = 1'b0;
    repeat (2) tick();

    // Config strobes during RUN are ignored.
    hist_clr();
    send_m(10, 0);
    cfg_we = 1'b1; cfg_addr = AW'(2); cfg_data = W_IN'(1);
    send_m(20, 0);
    cfg_we = 1'b0; cfg_commit = 1'b1;
    send_m(30, 1);
    cfg_commit = 1'b0;
    drain("cfg_in_run");
    chk("coeff_run_unchanged", dp_coeff, exp_coeff);

    // Reset with samples in flight.
    hist_clr(); m0 = mv_cnt;
    send(5, 0, t); send(6, 0, t); send(7, 0, t);
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_midrun_busy", busy, 0);
    chk("rst_midrun_coeff", dp_coeff, 0);
    repeat (10) tick();
    chk("rst_no_m_valid", mv_cnt - m0, 0);

    load_coeffs(1'b0);

    // Eight-sample stream with flush.
    hist_clr(); m0 = mv_cnt;
    for (int i = 0; i < 8; i++) send_m(smp[i], (i == 7));
    drain("flush8");
    chk("flush8_pulses", mv_cnt - m0, 8 + TAILN);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 SHALL have parameters: W_IN, default 11, sample/coefficient width; W_O, default 13, filter output width; L, default 4, tap count; MPIPE, default 3, multiplier pipeline stages.
REQ-002 SHALL have ports, clock and reset first: clk  in  1  single clock, all logic on rising edge; rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have config ports: cfg_we  in  1  coefficient write strobe; cfg_addr  in  clog2(L)  tap index; cfg_data  in  W_IN  signed coefficient; cfg_commit  in  1  apply shadow bank.
REQ-004 SHALL have sample-in ports: s_valid  in  1; s_data  in  W_IN  signed sample; s_ready  out  1.
REQ-005 SHALL have control/status ports: flush_req  in  1  end-of-stream; busy  out  1; underrun  out  1  one-cycle pulse.
REQ-006 SHALL have datapath ports: dp_load_val  out  1; dp_val_in  out  W_IN; dp_coeff  out  L*W_IN  (tap i at bits [i*W_IN +: W_IN]); dp_fir_out  in  W_O.
REQ-007 SHALL have result ports: m_valid  out  1; m_data  out  W_O.

Function
REQ-008 SHALL implement FSM states IDLE, LOAD, COMMIT, RUN, FLUSH.
REQ-009 IDLE: cfg_we -> LOAD (write captured); else s_valid -> RUN; cfg_we wins when both high.
REQ-010 LOAD: each cfg_we writes cfg_data into shadow[cfg_addr]; cfg_commit -> COMMIT; commit wins over a same-cycle cfg_we, which is dropped.
REQ-011 COMMIT: one cycle; shadow copied to dp_coeff; dp_load_val=0; then IDLE.
REQ-012 dp_load_val SHALL be 1 in every state except COMMIT.
REQ-013 cfg_we/cfg_commit SHALL be ignored in RUN, FLUSH and COMMIT.
REQ-014 RUN: s_ready=1; every cycle dp_val_in=s_data if s_valid else 0; s_valid=0 in RUN SHALL pulse underrun and inject zero untagged.
REQ-015 s_ready SHALL be 0 outside RUN.
REQ-016 dp_val_in SHALL be 0 outside RUN/FLUSH.
REQ-017 Latency LAT=MPIPE+2; a tag shift register of depth LAT SHALL carry 1 for each accepted sample, 0 otherwise.
REQ-018 m_valid SHALL equal the tag leaving the shift register; m_data=dp_fir_out when m_valid, else 0.
REQ-019 Accepted sample at cycle t SHALL yield m_valid at cycle t+LAT (t+5 by default).
REQ-020 busy SHALL be 1 when state!=IDLE or any tag bit set.
REQ-021 flush_req in RUN SHALL take effect after that cycle's sample; flush_req outside RUN ignored.

Reset
REQ-022 rst SHALL force: state IDLE; shadow, dp_coeff, dp_val_in, m_data all zero; tags cleared; s_ready, m_valid, underrun, busy 0; dp_load_val 1.
REQ-023 rst mid-RUN/FLUSH SHALL drop all in-flight tags; m_valid=0 from the cycle after rst is sampled.

Configuration
REQ-024 Macro FIR_CTRL_FLUSH_EN SHALL control tail flushing.
REQ-025 With FIR_CTRL_FLUSH_EN: RUN+flush_req -> FLUSH; FLUSH injects L-1 zeros tagged valid (tail outputs), then IDLE; s_ready=0 in FLUSH.
REQ-026 Without FIR_CTRL_FLUSH_EN: FLUSH state absent; RUN+flush_req -> IDLE directly; in-flight tags still drain normally.

Verification
REQ-027 Write coeffs 124,214,57,33 to taps 0..3, commit -> dp_load_val low exactly one cycle; dp_coeff matches next cycle.
REQ-028 Impulse: sample 1 then zeros, flush -> m_valid from cycle t+5; m_data sequence follows 124,214,57,33 scaled by top-W_O slice.
REQ-029 Drop s_valid one cycle mid-stream -> underrun one-cycle pulse, one missing m_valid slot LAT cycles later.
REQ-030 cfg_we with s_valid in IDLE -> LOAD; cfg_we during RUN -> dp_coeff unchanged.
REQ-031 rst two cycles after 3 samples accepted -> m_valid never asserts, busy=0 after reset.
REQ-032 Flush with 8 samples, FIR_CTRL_FLUSH_EN defined -> 11 m_valid pulses; undefined -> 8 pulses.
